// File: rtl/btb_predictor_if.sv
// Fetch-stage bus of the branch target buffer: the lookup port feeding the
// PC-update mux and the training port from the execute stage.
// Optional macro BTB_STATS_EN adds the statistics outputs.
interface btb_predictor_if;
    // lookup side
    logic [31:0] lookup_pc;
    logic [31:0] btb_target_pc;
    logic        btb_pc_valid;
    logic        btb_pc_predictTaken;
    // training side
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        flush;
`ifdef BTB_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    // Driver of lookups/updates (fetch + execute stages)
    modport master (
        output lookup_pc,
        input  btb_target_pc,
        input  btb_pc_valid,
        input  btb_pc_predictTaken,
        output update_en,
        output update_pc,
        output update_target,
        output update_taken,
        output flush
`ifdef BTB_STATS_EN
        ,
        input  stat_updates,
        input  stat_mispredicts
`endif
    );

    // The predictor itself
    modport slave (
        input  lookup_pc,
        output btb_target_pc,
        output btb_pc_valid,
        output btb_pc_predictTaken,
        input  update_en,
        input  update_pc,
        input  update_target,
        input  update_taken,
        input  flush
`ifdef BTB_STATS_EN
        ,
        output stat_updates,
        output stat_mispredicts
`endif
    );
endinterface

// File: rtl/btb_predictor.sv
// 2-way set-associative branch target buffer with 2-bit saturating direction
// counters. Lookup is combinational so the prediction reaches the PC mux in
// the same cycle; training happens at the clock edge from resolved branches.
// Optional macro BTB_STATS_EN adds saturating update/mispredict counters.
module btb_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    btb_predictor_if.slave bus
);
    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (ctr == 2'b11) begin
                nxt = 2'b11;
            end else begin
                nxt = ctr + 2'b01;
            end
        end else begin
            if (ctr == 2'b00) begin
                nxt = 2'b00;
            end else begin
                nxt = ctr - 2'b01;
            end
        end
        return nxt;
    endfunction

    // storage: [way][set]
    logic                valid_r  [2][SETS];
    logic [TAG_BITS-1:0] tag_r    [2][SETS];
    logic [31:0]         target_r [2][SETS];
    logic [1:0]          ctr_r    [2][SETS];
    logic [SETS-1:0]     lru_r;

    // lookup decode
    logic [INDEX_BITS-1:0] lk_idx_s;
    logic [TAG_BITS-1:0]   lk_tag_s;
    logic                  lk_hit0_s;
    logic                  lk_hit1_s;

    // update decode
    logic [INDEX_BITS-1:0] up_idx_s;
    logic [TAG_BITS-1:0]   up_tag_s;
    logic                  up_hit0_s;
    logic                  up_hit1_s;
    logic                  up_hit_s;
    logic                  up_hit_way_s;
    logic                  up_victim_s;
    logic                  up_accept_s;
    logic [1:0]            hit_ctr_s;
    logic [31:0]           hit_target_s;
    logic                  wr_en_s;
    logic                  wr_way_s;
    logic [1:0]            wr_ctr_s;
    logic [31:0]           wr_target_s;

    // PC bits [1:0] never select anything: instructions are word aligned.
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{bus.lookup_pc[1:0], bus.update_pc[1:0]};

    assign lk_idx_s  = bus.lookup_pc[INDEX_BITS+1:2];
    assign lk_tag_s  = bus.lookup_pc[31:INDEX_BITS+2];
    assign lk_hit0_s = valid_r[0][lk_idx_s] && (tag_r[0][lk_idx_s] == lk_tag_s);
    assign lk_hit1_s = valid_r[1][lk_idx_s] && (tag_r[1][lk_idx_s] == lk_tag_s);

    assign up_idx_s  = bus.update_pc[INDEX_BITS+1:2];
    assign up_tag_s  = bus.update_pc[31:INDEX_BITS+2];
    assign up_hit0_s = valid_r[0][up_idx_s] && (tag_r[0][up_idx_s] == up_tag_s);
    assign up_hit1_s = valid_r[1][up_idx_s] && (tag_r[1][up_idx_s] == up_tag_s);
    assign up_hit_s  = up_hit0_s | up_hit1_s;
    assign up_accept_s = bus.update_en & ~bus.flush;

    // Zero-latency prediction for the fetch PC; way0 wins a double hit.
    always_comb begin
        bus.btb_pc_valid        = 1'b0;
        bus.btb_pc_predictTaken = 1'b0;
        bus.btb_target_pc       = 32'h0000_0000;
        if (lk_hit0_s) begin
            bus.btb_pc_valid        = 1'b1;
            bus.btb_pc_predictTaken = ctr_r[0][lk_idx_s][1];
            bus.btb_target_pc       = target_r[0][lk_idx_s];
        end else if (lk_hit1_s) begin
            bus.btb_pc_valid        = 1'b1;
            bus.btb_pc_predictTaken = ctr_r[1][lk_idx_s][1];
            bus.btb_target_pc       = target_r[1][lk_idx_s];
        end else begin
            bus.btb_pc_valid        = 1'b0;
            bus.btb_pc_predictTaken = 1'b0;
            bus.btb_target_pc       = 32'h0000_0000;
        end
    end

    // Pick the hit way and the allocation victim of the update set.
    always_comb begin
        up_hit_way_s = 1'b0;
        up_victim_s  = 1'b0;
        if (up_hit0_s) begin
            up_hit_way_s = 1'b0;
        end else if (up_hit1_s) begin
            up_hit_way_s = 1'b1;
        end else begin
            up_hit_way_s = 1'b0;
        end
        if (!valid_r[0][up_idx_s]) begin
            up_victim_s = 1'b0;
        end else if (!valid_r[1][up_idx_s]) begin
            up_victim_s = 1'b1;
        end else begin
            up_victim_s = lru_r[up_idx_s];
        end
    end

    assign hit_ctr_s    = ctr_r[up_hit_way_s][up_idx_s];
    assign hit_target_s = target_r[up_hit_way_s][up_idx_s];

    // Decide what a resolved branch writes: train on a hit, allocate on a taken miss.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_way_s    = 1'b0;
        wr_ctr_s    = hit_ctr_s;
        wr_target_s = hit_target_s;
        if (up_hit_s) begin
            wr_en_s  = up_accept_s;
            wr_way_s = up_hit_way_s;
            wr_ctr_s = ctr_train(hit_ctr_s, bus.update_taken);
            if (bus.update_taken) begin
                wr_target_s = bus.update_target;
            end else begin
                wr_target_s = hit_target_s;
            end
        end else if (bus.update_taken) begin
            wr_en_s     = up_accept_s;
            wr_way_s    = up_victim_s;
            wr_ctr_s    = 2'b10;
            wr_target_s = bus.update_target;
        end else begin
            wr_en_s     = 1'b0;
            wr_way_s    = up_victim_s;
            wr_ctr_s    = hit_ctr_s;
            wr_target_s = hit_target_s;
        end
    end

    // Entry storage: reset, flush (valid bits only), or one-way write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < 2; w++) begin
                    valid_r[w][s]  <= 1'b0;
                    tag_r[w][s]    <= '0;
                    target_r[w][s] <= 32'h0000_0000;
                    ctr_r[w][s]    <= 2'b01;
                end
            end
            lru_r <= '0;
        end else if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[0][s] <= 1'b0;
                valid_r[1][s] <= 1'b0;
            end
        end else if (wr_en_s) begin
            valid_r[wr_way_s][up_idx_s]  <= 1'b1;
            tag_r[wr_way_s][up_idx_s]    <= up_tag_s;
            target_r[wr_way_s][up_idx_s] <= wr_target_s;
            ctr_r[wr_way_s][up_idx_s]    <= wr_ctr_s;
            lru_r[up_idx_s]              <= ~wr_way_s;
        end else begin
            lru_r <= lru_r;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_updates_r;
    logic [31:0] stat_mispredicts_r;
    logic        mispredict_s;

    // Wrong direction, or right "taken" call but stale target.
    assign mispredict_s = ((up_hit_s & hit_ctr_s[1]) != bus.update_taken) |
                          (bus.update_taken & up_hit_s & hit_ctr_s[1] &
                           (hit_target_s != bus.update_target));

    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_updates_r     <= 32'h0000_0000;
            stat_mispredicts_r <= 32'h0000_0000;
        end else if (up_accept_s) begin
            if (stat_updates_r != 32'hFFFF_FFFF) begin
                stat_updates_r <= stat_updates_r + 32'd1;
            end else begin
                stat_updates_r <= stat_updates_r;
            end
            if (mispredict_s && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end else begin
                stat_mispredicts_r <= stat_mispredicts_r;
            end
        end else begin
            stat_updates_r     <= stat_updates_r;
            stat_mispredicts_r <= stat_mispredicts_r;
        end
    end

    assign bus.stat_updates     = stat_updates_r;
    assign bus.stat_mispredicts = stat_mispredicts_r;
`endif

endmodule
